sprite_blit: RTL and testbench
==============================

Name: sprite_blit

Overview:
- Parametrised, pipelined tile blitter for the VGA framebuffer.
- Copies a TILE_W x TILE_H sprite from sprite ROM to the grid cell (tile_x, tile_y) in the framebuffer, one pixel per clock.
- Modes: opaque copy, colour-keyed (transparent) copy, horizontally mirrored keyed copy, and solid fill.
- Sits between the game-logic draw scheduler and the framebuffer write port; the scheduler supplies the ROM base address directly, so the blitter has no hardwired sprite index table.

Parameters:
- SCREEN_W, 640, framebuffer width in pixels.
- SCREEN_H, 480, framebuffer height in pixels.
- TILE_W, 29, sprite width in pixels.
- TILE_H, 29, sprite height in pixels.
- GRID_X0, 102, pixel x of grid cell (0,0).
- GRID_Y0, 22, pixel y of grid cell (0,0).
- MEM_LAT, 2, ROM read latency in cycles, from rd_addr to valid rd_data (1..4).
- ROM_AW, 15, ROM address width.
- FB_AW, 19, framebuffer address width.
- PIX_W, 8, pixel width.
- KEY, 8'hE3, transparent colour for keyed modes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  start request.
- rdy  out  1  idle; a start is accepted at a rising edge where en=1 and rdy=1.
- tile_x  in  5  grid column, latched at accept.
- tile_y  in  5  grid row, latched at accept.
- sprite_base  in  ROM_AW  ROM address of sprite pixel (0,0), latched at accept.
- mode  in  2  00 opaque, 01 keyed, 10 fill, 11 keyed+hflip; latched at accept.
- fill_color  in  PIX_W  fill value, latched at accept.
- rd_addr  out  ROM_AW  ROM read address.
- rd_data  in  PIX_W  ROM read data.
- wr_addr  out  FB_AW  framebuffer address.
- wr_data  out  PIX_W  framebuffer data.
- wren  out  1  framebuffer write strobe.
- done  out  1  one-cycle pulse when a blit completes.

Behaviour:
- Reset: rdy=1, wren=0, done=0, rd_addr=0, wr_addr=0, wr_data=0, FSM=IDLE, pipeline valid bits cleared.
- Reset mid-blit aborts immediately; no further wren.
- FSM states:
  - IDLE: rdy=1. Accept -> ISSUE; rdy=0 on the next cycle.
  - ISSUE: N=TILE_W*TILE_H cycles, one pixel per cycle in raster order (col 0..TILE_W-1, then next row). ISSUE -> DRAIN after the last pixel.
  - DRAIN: MEM_LAT cycles. DRAIN -> DONE.
  - DONE: 1 cycle, done=1, rdy=1. DONE -> IDLE.
- en while rdy=0 is ignored and not queued. Latched inputs are unaffected by input changes during a blit.
- Accept at edge T: issue cycles T+1 .. T+N; pixel k issued at T+1+k.
- Read address for pixel (r,c): rd_addr = sprite_base + r*TILE_W + c'.
  - c' = c for modes 00/01/10.
  - c' = TILE_W-1-c for mode 11.
  - Computed incrementally; no multiplier in the per-pixel path.
- In fill mode rd_addr still steps but rd_data is ignored.
- Framebuffer origin: X0 = GRID_X0 + tile_x*TILE_W, Y0 = GRID_Y0 + tile_y*TILE_H. Computed once at accept, with width wide enough to hold 31*TILE_W + GRID_X0 without overflow.
- Pixel (r,c) goes to wr_addr = (Y0+r)*SCREEN_W + (X0+c). Computed as a running address: +1 per column, + (SCREEN_W - TILE_W + 1) at each row wrap.
- Pipeline: pixel k's address, in-screen flag and valid bit are delayed MEM_LAT cycles. wren for pixel k is asserted in cycle T+1+k+MEM_LAT, with wr_data = rd_data (fill_color in fill mode).
- wren is suppressed when either:
  - X0+c >= SCREEN_W or Y0+r >= SCREEN_H (clipping); or
  - mode is 01 or 11 and rd_data == KEY.
- wr_addr and wr_data are don't-care when wren=0.
- Total blit time is fixed at N + MEM_LAT + 1 cycles after accept, regardless of clipping or keying. done is at T+N+MEM_LAT+1.
- Accept in the DONE cycle is not possible. The earliest next accept is the edge following DONE (back-to-back rate: one blit per N+MEM_LAT+2 cycles).

Test Plan:
- Defaults, mode 00, tile (0,0), sprite_base 0, accept at T -> rd_addr=0 at T+1. First wren at T+3 with wr_addr=14182. Pixel 29 -> wr_addr=14822. Last pixel at T+843 -> wr_addr=32130. done=1 and rdy=1 at T+844. Exactly 841 wren pulses.
- Mode 01, ROM where every pixel in even columns = 8'hE3 -> only odd-column pixels written: 14 per row, 406 wren total. done still at T+844.
- Mode 11, tile (14,14), sprite_base 841 -> first rd_addr=869. First wr_addr = 428*640+508 = 274428, with data from ROM[869].
- Mode 10, fill_color 8'h00, tile (3,5) -> 841 writes of 0 starting at wr_addr = 167*640+189 = 107069.
- tile_x=31 (X0=1001, off-screen) -> zero wren pulses, done at T+844. Assert en again during the blit -> ignored.
- Reset asserted at T+200 -> wren=0, rdy=1 the next cycle. A new accept then completes normally with 841 writes.

Source files
------------

// File: rtl/sprite_blit.sv
// sprite_blit: pipelined tile blitter for the VGA framebuffer.
// Copies a TILE_W x TILE_H sprite from sprite ROM to grid cell
// (tile_x, tile_y), one pixel per clock, with opaque / keyed / fill /
// keyed+hflip modes. Clipped and keyed pixels still take their slot, so a
// blit always lasts N + MEM_LAT + 1 cycles after accept.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_en / o_rdy        start handshake (accepted when both high in IDLE)
//   i_tile_x, i_tile_y  grid cell, latched at accept
//   i_sprite_base       ROM address of sprite pixel (0,0), latched at accept
//   i_mode              00 opaque, 01 keyed, 10 fill, 11 keyed+hflip
//   i_fill_color        fill value, latched at accept
//   o_rd_addr/i_rd_data ROM read port, MEM_LAT cycles of read latency
//   o_wr_addr, o_wr_data, o_wren  framebuffer write port
//   o_done              one-cycle pulse at blit completion
module sprite_blit #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int TILE_W   = 29,
  parameter int TILE_H   = 29,
  parameter int GRID_X0  = 102,
  parameter int GRID_Y0  = 22,
  parameter int MEM_LAT  = 2,
  parameter int ROM_AW   = 15,
  parameter int FB_AW    = 19,
  parameter int PIX_W    = 8,
  parameter logic [PIX_W-1:0] KEY = 8'hE3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  output logic              o_rdy,
  input  logic [4:0]        i_tile_x,
  input  logic [4:0]        i_tile_y,
  input  logic [ROM_AW-1:0] i_sprite_base,
  input  logic [1:0]        i_mode,
  input  logic [PIX_W-1:0]  i_fill_color,
  output logic [ROM_AW-1:0] o_rd_addr,
  input  logic [PIX_W-1:0]  i_rd_data,
  output logic [FB_AW-1:0]  o_wr_addr,
  output logic [PIX_W-1:0]  o_wr_data,
  output logic              o_wren,
  output logic              o_done
);

  // Coordinate width: must hold the far edge of the farthest grid cell.
  localparam int XMAX = 31 * TILE_W + GRID_X0 + TILE_W;
  localparam int YMAX = 31 * TILE_H + GRID_Y0 + TILE_H;
  localparam int CMAX = (XMAX > YMAX) ? XMAX : YMAX;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int CCW  = $clog2(TILE_W + 1);
  localparam int RCW  = $clog2(TILE_H + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                        r_state;
  logic [1:0]                    r_mode;
  logic [PIX_W-1:0]              r_fill;
  logic [CW-1:0]                 r_x0, r_x, r_y;
  logic [CCW-1:0]                r_col;
  logic [RCW-1:0]                r_row;
  logic [ROM_AW-1:0]             r_rd_addr;
  logic [2:0]                    r_cnt;
  // Stage 0 is the issue stage; stage MEM_LAT lines up with i_rd_data.
  logic [MEM_LAT:0]              r_vld_pipe;
  logic [MEM_LAT:0]              r_ins_pipe;
  logic [MEM_LAT:0][FB_AW-1:0]   r_fb_pipe;

  logic [CW-1:0]    w_x0, w_y0, w_nx, w_ny;
  logic [FB_AW-1:0] w_fb0;
  logic             w_col_last, w_row_last, w_hflip, w_key_hit;

  // Cell origin: constant multiplies, evaluated only at accept.
  assign w_x0  = CW'(GRID_X0) + CW'(i_tile_x) * CW'(TILE_W);
  assign w_y0  = CW'(GRID_Y0) + CW'(i_tile_y) * CW'(TILE_H);
  assign w_fb0 = FB_AW'(w_y0) * FB_AW'(SCREEN_W) + FB_AW'(w_x0);

  assign w_col_last = (r_col == CCW'(TILE_W - 1));
  assign w_row_last = (r_row == RCW'(TILE_H - 1));
  assign w_hflip    = (r_mode == 2'b11);

  // Screen coordinate of the pixel issued next cycle; its in-screen flag is
  // registered alongside it so clipping rides the same pipe as the address.
  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    if (r_state == S_IDLE) begin
      w_nx = w_x0;
      w_ny = w_y0;
    end else if (r_state == S_ISSUE) begin
      if (w_col_last) begin
        w_nx = r_x0;
        w_ny = r_y + CW'(1);
      end else begin
        w_nx = r_x + CW'(1);
      end
    end
  end

  assign w_key_hit = r_mode[0] && (i_rd_data == KEY);
  assign o_rd_addr = r_rd_addr;
  assign o_wren    = r_vld_pipe[MEM_LAT] && r_ins_pipe[MEM_LAT] && !w_key_hit;
  assign o_wr_addr = r_vld_pipe[MEM_LAT] ? r_fb_pipe[MEM_LAT] : '0;
  assign o_wr_data = !r_vld_pipe[MEM_LAT] ? '0 :
                     (r_mode == 2'b10)    ? r_fill : i_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      o_rdy      <= 1'b1;
      o_done     <= 1'b0;
      r_mode     <= '0;
      r_fill     <= '0;
      r_x0       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_rd_addr  <= '0;
      r_cnt      <= '0;
      r_vld_pipe <= '0;
      r_ins_pipe <= '0;
      r_fb_pipe  <= '0;
    end else begin
      r_vld_pipe[MEM_LAT:1] <= r_vld_pipe[MEM_LAT-1:0];
      r_ins_pipe[MEM_LAT:1] <= r_ins_pipe[MEM_LAT-1:0];
      r_fb_pipe[MEM_LAT:1]  <= r_fb_pipe[MEM_LAT-1:0];
      r_vld_pipe[0] <= 1'b0;
      r_ins_pipe[0] <= (w_nx < CW'(SCREEN_W)) && (w_ny < CW'(SCREEN_H));
      r_x           <= w_nx;
      r_y           <= w_ny;
      o_done        <= 1'b0;
      case (r_state)
        S_IDLE: if (i_en) begin
          r_mode        <= i_mode;
          r_fill        <= i_fill_color;
          r_x0          <= w_x0;
          r_col         <= '0;
          r_row         <= '0;
          r_fb_pipe[0]  <= w_fb0;
          // hflip walks each row right to left
          r_rd_addr     <= i_sprite_base +
                           ((i_mode == 2'b11) ? ROM_AW'(TILE_W - 1) : '0);
          r_vld_pipe[0] <= 1'b1;
          o_rdy         <= 1'b0;
          r_state       <= S_ISSUE;
        end
        S_ISSUE: begin
          if (w_col_last) begin
            r_col        <= '0;
            r_row        <= r_row + RCW'(1);
            r_fb_pipe[0] <= r_fb_pipe[0] + FB_AW'(SCREEN_W - TILE_W + 1);
            r_rd_addr    <= r_rd_addr +
                            (w_hflip ? ROM_AW'(2 * TILE_W - 1) : ROM_AW'(1));
          end else begin
            r_col        <= r_col + CCW'(1);
            r_fb_pipe[0] <= r_fb_pipe[0] + FB_AW'(1);
            r_rd_addr    <= w_hflip ? r_rd_addr - ROM_AW'(1)
                                    : r_rd_addr + ROM_AW'(1);
          end
          if (w_col_last && w_row_last) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_vld_pipe[0] <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_cnt == 3'(MEM_LAT - 1)) begin
            o_done  <= 1'b1;
            o_rdy   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;  // S_DONE: rdy already high, no accept
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blit.sv
// Testbench for sprite_blit: randomised ROM contents and blit parameters,
// checked cycle by cycle against a per-pixel reference model.
module tb_sprite_blit;
  localparam int TW = 29, TH = 29, ML = 2, N = TW * TH, TOT = N + ML + 1;
  localparam int SW = 640, SH = 480, GX = 102, GY = 22;

  logic        clk = 1'b0;
  logic        rst, en, rdy, wren, done;
  logic [4:0]  tile_x, tile_y;
  logic [14:0] base, rd_addr;
  logic [1:0]  mode;
  logic [7:0]  fill, rd_data, wr_data;
  logic [18:0] wr_addr;

  always #5 clk = ~clk;

  sprite_blit dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .o_rdy(rdy),
    .i_tile_x(tile_x), .i_tile_y(tile_y), .i_sprite_base(base),
    .i_mode(mode), .i_fill_color(fill), .o_rd_addr(rd_addr),
    .i_rd_data(rd_data), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_wren(wren), .o_done(done)
  );

  // ROM with two cycles of read latency
  logic [7:0] rom [0:32767];
  logic [7:0] s1, s2;
  always @(posedge clk) begin
    s1 <= rom[rd_addr];
    s2 <= s1;
  end
  assign rd_data = s2;

  int checks = 0, errors = 0;
  int obs_cnt, obs_first_j, obs_last_j, obs_rd1;
  int obs_q[$];
  logic [7:0] obs_first_data;

  function automatic logic [7:0] nonkey();
    logic [7:0] v;
    v = 8'($urandom);
    if (v == 8'hE3) v = 8'h00;
    return v;
  endfunction

  task automatic fill_rom_random();
    for (int i = 0; i < 32768; i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? 8'hE3 : nonkey();
  endtask

  // One blit from accept to one cycle past DONE. rs>0 asserts reset so the
  // edge ending cycle T+rs sees it. hold keeps en high and scrambles inputs.
  task automatic run_blit(input int tx, input int ty, input int b, input int md,
                          input logic [7:0] fc, input bit hold, input int rs);
    bit         ew [0:TOT+1];
    int         ea [0:TOT+1];
    logic [7:0] ed [0:TOT+1];
    int         er [0:TOT+1];
    int x0, y0, lim, r, c, cp, ra, j, wm, rm, tm, fj, fa, fe;
    logic [7:0] pix;
    x0 = GX + tx * TW;
    y0 = GY + ty * TH;
    lim = (rs > 0) ? rs : TOT + 1;
    for (int i = 0; i <= TOT + 1; i++) begin
      ew[i] = 0; ea[i] = 0; ed[i] = 0; er[i] = -1;
    end
    for (int k = 0; k < N; k++) begin
      r = k / TW; c = k % TW;
      cp = (md == 3) ? TW - 1 - c : c;
      ra = b + r * TW + cp;
      if (1 + k <= lim) er[1 + k] = ra;
      pix = rom[ra];
      j = 1 + k + ML;
      if (j <= lim && x0 + c < SW && y0 + r < SH &&
          !((md == 1 || md == 3) && pix == 8'hE3)) begin
        ew[j] = 1;
        ea[j] = (y0 + r) * SW + x0 + c;
        ed[j] = (md == 2) ? fc : pix;
      end
    end
    en = 1; tile_x = 5'(tx); tile_y = 5'(ty); base = 15'(b);
    mode = 2'(md); fill = fc;
    @(posedge clk); #1;
    if (!hold) en = 0;
    tile_x = 5'($urandom); tile_y = 5'($urandom); base = 15'($urandom);
    mode = 2'($urandom); fill = 8'($urandom);
    wm = 0; rm = 0; tm = 0; fj = 0; fa = 0; fe = 0;
    obs_cnt = 0; obs_first_j = -1; obs_last_j = -1; obs_rd1 = -1;
    obs_first_data = 0; obs_q = {};
    for (int jj = 1; jj <= TOT + 1; jj++) begin
      @(negedge clk);
      if (jj == 1) obs_rd1 = int'(rd_addr);
      if (rdy !== ((rs > 0 && jj > rs) || jj >= TOT) ||
          done !== (!(rs > 0 && jj > rs) && jj == TOT)) tm++;
      if (wren !== ew[jj] ||
          (wren === 1'b1 && (int'(wr_addr) != ea[jj] || wr_data !== ed[jj]))) begin
        if (wm == 0) begin fj = jj; fa = int'(wr_addr); fe = ea[jj]; end
        wm++;
      end
      if (er[jj] >= 0 && int'(rd_addr) != er[jj]) rm++;
      if (wren === 1'b1) begin
        if (obs_first_j < 0) begin obs_first_j = jj; obs_first_data = wr_data; end
        obs_last_j = jj;
        obs_q.push_back(int'(wr_addr));
        obs_cnt++;
      end
      if (rs > 0 && jj == rs) rst = 1;
      if (rs > 0 && jj == rs + 1) rst = 0;
    end
    checks++;
    if (wm != 0) begin
      errors++;
      $display("FAIL write_stream: %0d bad cycles, first at T+%0d wren=%0b addr=%0d want wren=%0b addr=%0d",
               wm, fj, wren, fa, ew[fj], fe);
    end
    checks++;
    if (rm != 0) begin errors++; $display("FAIL rd_addr_seq: %0d bad cycles, want 0", rm); end
    checks++;
    if (tm != 0) begin errors++; $display("FAIL rdy_done_timing: %0d bad cycles, want 0", tm); end
  endtask

  task automatic test_reset();
    rst = 1; en = 0; tile_x = 0; tile_y = 0; base = 0; mode = 0; fill = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (rdy !== 1'b1)     begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy); end
    if (wren !== 1'b0)    begin errors++; $display("FAIL reset_wren: got %b want 0", wren); end
    if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (rd_addr !== '0)   begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    if (wr_addr !== '0)   begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    if (wr_data !== '0)   begin errors++; $display("FAIL reset_wr_data: got %0d want 0", wr_data); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_opaque();
    fill_rom_random();
    run_blit(0, 0, 0, 0, 8'h00, 0, 0);
    checks += 5;
    if (obs_cnt != 841) begin errors++; $display("FAIL opaque_count: got %0d want 841", obs_cnt); end
    if (obs_rd1 != 0) begin errors++; $display("FAIL opaque_rd1: got %0d want 0", obs_rd1); end
    if (obs_first_j != 3 || obs_q.size() < 1 || obs_q[0] != 14182) begin
      errors++; $display("FAIL opaque_first: at T+%0d addr %0d want T+3 addr 14182",
                         obs_first_j, (obs_q.size() > 0) ? obs_q[0] : -1);
    end
    if (obs_q.size() < 30 || obs_q[29] != 14822) begin
      errors++; $display("FAIL opaque_px29: got %0d want 14822", (obs_q.size() > 29) ? obs_q[29] : -1);
    end
    if (obs_last_j != 843 || obs_q.size() < 1 || obs_q[obs_q.size()-1] != 32130) begin
      errors++; $display("FAIL opaque_last: at T+%0d addr %0d want T+843 addr 32130",
                         obs_last_j, (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : -1);
    end
  endtask

  task automatic test_keyed();
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < TW; c++)
        rom[2000 + r * TW + c] = (c % 2 == 0) ? 8'hE3 : nonkey();
    run_blit(2, 3, 2000, 1, 8'h00, 0, 0);
    checks++;
    if (obs_cnt != 406) begin errors++; $display("FAIL keyed_count: got %0d want 406", obs_cnt); end
  endtask

  task automatic test_hflip();
    fill_rom_random();
    rom[869] = nonkey();
    run_blit(14, 14, 841, 3, 8'h00, 0, 0);
    checks += 2;
    if (obs_rd1 != 869) begin errors++; $display("FAIL hflip_rd1: got %0d want 869", obs_rd1); end
    if (obs_q.size() < 1 || obs_q[0] != 274428 || obs_first_data !== rom[869]) begin
      errors++; $display("FAIL hflip_first: addr %0d data %0h want 274428 data %0h",
                         (obs_q.size() > 0) ? obs_q[0] : -1, obs_first_data, rom[869]);
    end
  endtask

  task automatic test_fill();
    run_blit(3, 5, 100, 2, 8'h00, 0, 0);
    checks += 2;
    if (obs_cnt != 841) begin errors++; $display("FAIL fill_count: got %0d want 841", obs_cnt); end
    if (obs_q.size() < 1 || obs_q[0] != 107069 || obs_first_data !== 8'h00) begin
      errors++; $display("FAIL fill_first: addr %0d data %0h want 107069 data 00",
                         (obs_q.size() > 0) ? obs_q[0] : -1, obs_first_data);
    end
  endtask

  // Off-screen blit with en held and inputs scrambled, then an immediate
  // second blit: it must be accepted exactly one cycle after DONE.
  task automatic test_back_to_back();
    run_blit(31, 4, 300, 0, 8'h11, 1, 0);
    checks++;
    if (obs_cnt != 0) begin errors++; $display("FAIL offscreen_count: got %0d want 0", obs_cnt); end
    run_blit(18, 16, 5000, 1, 8'h22, 0, 0);
  endtask

  task automatic test_reset_mid();
    run_blit(1, 1, 400, 0, 8'h00, 0, 200);
    checks++;
    if (obs_cnt != 198) begin errors++; $display("FAIL midreset_count: got %0d want 198", obs_cnt); end
    run_blit(4, 2, 700, 0, 8'h00, 0, 0);
    checks++;
    if (obs_cnt != 841) begin errors++; $display("FAIL post_reset_count: got %0d want 841", obs_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++)
      run_blit($urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31000), $urandom_range(0, 3),
               8'($urandom), 1'($urandom), 0);
    en = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_opaque();
    test_keyed();
    test_hflip();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
